// File: rtl/prog_counter.sv
// Programmable up/down counter with load, wrap limit, saturate mode and step prescaler.
// Emits a one-cycle tick per step and a terminal-count pulse when a bound is hit.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  tc
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  step;
  logic [WIDTH-1:0]      step_count;
  logic                  step_tc;
  logic [WIDTH-1:0]      load_clamped;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    step         = (pcnt >= prescale);
    step_count   = count;
    step_tc      = 1'b0;
    load_clamped = (load_val > limit) ? limit : load_val;
    if (up) begin
      if (count >= limit) begin
        step_count = sat ? limit : '0;
        step_tc    = 1'b1;
      end else begin
        step_count = count + 1'b1;
      end
    end else begin
      // A count stranded above a freshly lowered limit snaps back without a tc pulse.
      if (count > limit) begin
        step_count = limit;
      end else if (count == '0) begin
        step_count = sat ? '0 : limit;
        step_tc    = 1'b1;
      end else begin
        step_count = count - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      pcnt  <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      pcnt  <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (en) begin
      if (step) begin
        count <= step_count;
        pcnt  <= '0;
        tick  <= 1'b1;
        tc    <= step_tc;
      end else begin
        pcnt  <= pcnt + 1'b1;
        tick  <= 1'b0;
        tc    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (WIDTH=8, PRESCALE_W=4).
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, sat, load;
  logic [7:0] load_val, limit;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tick, tc;

  int tests_run = 0;
  int tests_failed = 0;

  prog_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .limit(limit), .prescale(prescale),
    .count(count), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int c, input int tk, input int t);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tick"},  32'(tick),  32'(tk));
    check({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int exp_c;
    int t4_cnt[9] = '{1, 2, 3, 3, 3, 2, 1, 0, 0};
    int t4_tc[9]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
    int t3_cnt[7] = '{5, 4, 3, 2, 1, 0, 5};
    int t3_tc[7]  = '{1, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
    load_val = 8'd0; limit = 8'd255; prescale = 4'd0;
    #23;
    check_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    check_out("idle", 0, 0, 0);

    // T1: plain modulo-256 counter.
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      check_out("t1", i % 256, 1, (i == 256) ? 1 : 0);
    end

    // T2: limit 9, step every third enabled cycle.
    en = 1'b0; limit = 8'd9; prescale = 4'd2;
    do_load(8'd0);
    check_out("t2.load", 0, 0, 0);
    en = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      cyc();
      if (e % 3 == 0) check_out("t2.step", (e / 3) % 10, 1, (e == 30) ? 1 : 0);
      else            check_out("t2.wait", (e / 3) % 10, 0, 0);
    end

    // T3: down count with wrap to limit.
    en = 1'b0; up = 1'b0; limit = 8'd5; prescale = 4'd0;
    do_load(8'd0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check_out("t3", t3_cnt[i], 1, t3_tc[i]);
    end

    // T4: saturate up to 3, then down to 0.
    en = 1'b0; up = 1'b1; sat = 1'b1; limit = 8'd3;
    do_load(8'd0);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) up = 1'b0;
      cyc();
      check_out("t4", t4_cnt[i], 1, t4_tc[i]);
    end

    // T5: clamped load clears the prescaler; en=0 holds.
    sat = 1'b0; up = 1'b1; limit = 8'd100; prescale = 4'd3; en = 1'b0;
    do_load(8'd0);
    en = 1'b1;
    cyc();
    cyc();
    check_out("t5.pre", 0, 0, 0);
    load = 1'b1; load_val = 8'd200;
    cyc();
    load = 1'b0;
    check_out("t5.load", 100, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_out("t5.hold", 100, 0, 0);
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i < 4) check_out("t5.wait", 100, 0, 0);
      else       check_out("t5.wrap", 0, 1, 1);
    end

    // Load below limit is taken unclamped.
    en = 1'b0;
    do_load(8'd42);
    check_out("load.small", 42, 0, 0);

    // T6: asynchronous reset mid-count.
    limit = 8'd255; prescale = 4'd0;
    do_load(8'd36);
    en = 1'b1;
    cyc();
    check_out("t6.pre", 37, 1, 0);
    prescale = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t6.async", 0, 0, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i < 3) check_out("t6.wait", 0, 0, 0);
      else       check_out("t6.step", 1, 1, 0);
    end

    // limit=0: held at 0, tc on every step, both directions.
    en = 1'b0; limit = 8'd0; prescale = 4'd0;
    do_load(8'd5);
    check_out("lim0.load", 0, 0, 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) up = 1'b0;
      cyc();
      check_out("lim0", 0, 1, 1);
    end

    // Down count above a lowered limit snaps to limit without tc.
    en = 1'b0; limit = 8'd255;
    do_load(8'd50);
    limit = 8'd20; en = 1'b1;
    exp_c = 20;
    cyc();
    check_out("snap", exp_c, 1, 0);
    cyc();
    check_out("snap.next", exp_c - 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
